// File: rtl/csr_hpm_counters_pkg.sv
// ---------------------------------------------------------------------------
// csr_hpm_counters_pkg
// Shared CSR address constants for the machine counter block plus a small
// helper that tests whether an address falls in a 32-entry CSR block.
// Optional feature macro used by the block: SSCOFPMF_EN (overflow flags).
// ---------------------------------------------------------------------------
package csr_hpm_counters_pkg;

   localparam logic [11:0] MCYCLE          = 12'hB00;
   localparam logic [11:0] MINSTRET        = 12'hB02;
   localparam logic [11:0] MHPMCOUNTER3    = 12'hB03;
   localparam logic [11:0] MHPMEVENT3      = 12'h323;
   localparam logic [11:0] MHPMEVENTH3     = 12'h723;
   localparam logic [11:0] CSR_HIGH_OFFSET = 12'h080;

   // Every counter/event family occupies one aligned 32-entry block, so the
   // low five address bits are the counter index within the block.
   function automatic logic same_block(input logic [11:0] adr, input logic [11:0] base);
      return adr[11:5] == base[11:5];
   endfunction

endpackage

// File: rtl/csr_hpm_counters_if.sv
// ---------------------------------------------------------------------------
// csr_hpm_counters_if
// CSR access bus between the CSR file (master) and the counter block (slave).
//   CSRWriteM            qualified write strobe
//   CSRAdrM              12-bit CSR address
//   CSRWriteValM         write data, XLEN bits
//   CSRHPMReadValM       combinational read data, XLEN bits
//   IllegalCSRHPMAccessM address in block range but illegal for this XLEN
// ---------------------------------------------------------------------------
interface csr_hpm_counters_if #(parameter int XLEN = 64);

   logic            CSRWriteM;
   logic [11:0]     CSRAdrM;
   logic [XLEN-1:0] CSRWriteValM;
   logic [XLEN-1:0] CSRHPMReadValM;
   logic            IllegalCSRHPMAccessM;

   modport master (
      output CSRWriteM, CSRAdrM, CSRWriteValM,
      input  CSRHPMReadValM, IllegalCSRHPMAccessM
   );

   modport slave (
      input  CSRWriteM, CSRAdrM, CSRWriteValM,
      output CSRHPMReadValM, IllegalCSRHPMAccessM
   );

endinterface

// File: rtl/csr_hpm_counters_hpmcounter.sv
// ---------------------------------------------------------------------------
// csr_hpm_counters_hpmcounter
// One 64-bit counter with count enable and a two-half write port.
//   clk, reset            clock, synchronous active-high reset
//   en                    increment this cycle
//   wr_lo / wr_lo_data    replace bits [31:0]
//   wr_hi / wr_hi_data    replace bits [63:32]
//   count                 current value
//   wrap                  this cycle's increment takes all-ones to zero
// A write in either half suppresses the increment for that cycle.
// ---------------------------------------------------------------------------
module csr_hpm_counters_hpmcounter (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wr_lo_data,
   input  logic [31:0] wr_hi_data,
   output logic [63:0] count,
   output logic        wrap
);

   logic [63:0] count_reg;

   assign wrap  = en & ~(wr_lo | wr_hi) & (&count_reg);
   assign count = count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else if (wr_lo | wr_hi) begin
         if (wr_lo) count_reg[31:0]  <= wr_lo_data;
         if (wr_hi) count_reg[63:32] <= wr_hi_data;
      end else if (en) begin
         count_reg <= count_reg + 64'd1;
      end
   end

endmodule

// File: rtl/csr_hpm_counters.sv
// ---------------------------------------------------------------------------
// csr_hpm_counters
// Machine cycle / instret / hardware performance-monitor counter block.
//   clk, reset            clock, synchronous active-high reset
//   csr                   CSR access bus (slave modport)
//   InstrRetiredM         an instruction retires this cycle
//   EventM                per-cycle event pulses, bit k is event k+1
//   MCOUNTINHIBIT_REGW    inhibit bits: 0 cycle, 2 instret, N counter N
//   LCOFIRQM              local counter-overflow interrupt pending
// Parameters: XLEN (32/64), NUM_HPM (0..29), NUM_EVENTS (1..255).
// Optional feature macro: SSCOFPMF_EN adds a sticky overflow flag per
// mhpmeventN (RV64 bit 63, RV32 mhpmeventhN bit 31) and drives LCOFIRQM.
// ---------------------------------------------------------------------------
module csr_hpm_counters
   import csr_hpm_counters_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int NUM_HPM    = 4,
   parameter int NUM_EVENTS = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   csr_hpm_counters_if.slave     csr,
   input  logic                  InstrRetiredM,
   input  logic [NUM_EVENTS-1:0] EventM,
   input  logic [31:0]           MCOUNTINHIBIT_REGW,
   output logic                  LCOFIRQM
);

   localparam int LAST_CNT = 2 + NUM_HPM;

   logic [63:0]  wv64;
   logic [11:0]  adr;
   logic [4:0]   idx;
   logic         is_cnt_blk, is_cnth_blk, is_evt_blk, is_evth_blk;
   logic [63:0]  cnt [0:31];
   logic [7:0]   sel_reg [0:31];
   logic [31:0]  of_reg, of_next, wrap_vec;
   logic [255:0] ev_pad;
   logic [63:0]  rd64;
   logic         unused_bits;

   assign wv64        = 64'(csr.CSRWriteValM);
   assign adr         = csr.CSRAdrM;
   assign idx         = adr[4:0];
   assign is_cnt_blk  = same_block(adr, MCYCLE);
   assign is_cnth_blk = same_block(adr, MCYCLE + CSR_HIGH_OFFSET);
   assign is_evt_blk  = same_block(adr, MHPMEVENT3);
   assign is_evth_blk = same_block(adr, MHPMEVENTH3);

   // Event vector shifted up by one so a selector indexes it directly:
   // sel=0 hits the constant-0 bit and sel>NUM_EVENTS hits zero padding.
   always_comb begin
      ev_pad = '0;
      ev_pad[NUM_EVENTS:1] = EventM;
   end

   genvar gi;
   for (gi = 0; gi < 32; gi++) begin : g_cnt
      if (gi == 0 || (gi >= 2 && gi <= LAST_CNT)) begin : g_impl
         logic en, wr_lo, wr_hi;
         if (gi == 0) begin : g_en_cycle
            assign en = ~MCOUNTINHIBIT_REGW[0];
         end else if (gi == 2) begin : g_en_instret
            assign en = InstrRetiredM & ~MCOUNTINHIBIT_REGW[2];
         end else begin : g_en_hpm
            assign en = ~MCOUNTINHIBIT_REGW[gi] & ev_pad[sel_reg[gi]];
         end
         assign wr_lo = csr.CSRWriteM & is_cnt_blk & (idx == 5'(gi));
         // RV64 writes the full counter through the low address
         assign wr_hi = csr.CSRWriteM & (idx == 5'(gi)) &
                        ((XLEN == 64) ? is_cnt_blk : is_cnth_blk);
         csr_hpm_counters_hpmcounter u_counter (
            .clk        (clk),
            .reset      (reset),
            .en         (en),
            .wr_lo      (wr_lo),
            .wr_hi      (wr_hi),
            .wr_lo_data (wv64[31:0]),
            .wr_hi_data ((XLEN == 64) ? wv64[63:32] : wv64[31:0]),
            .count      (cnt[gi]),
            .wrap       (wrap_vec[gi])
         );
      end else begin : g_none
         assign cnt[gi]      = '0;
         assign wrap_vec[gi] = 1'b0;
      end

      if (gi >= 3 && gi <= LAST_CNT) begin : g_evt
         logic [7:0] sel_r;
         always_ff @(posedge clk) begin
            if (reset)
               sel_r <= '0;
            else if (csr.CSRWriteM & is_evt_blk & (idx == 5'(gi)))
               sel_r <= wv64[7:0];
         end
         assign sel_reg[gi] = sel_r;
`ifdef SSCOFPMF_EN
         logic of_r, of_nxt, of_wr;
         assign of_wr  = csr.CSRWriteM & (idx == 5'(gi)) &
                         ((XLEN == 64) ? is_evt_blk : is_evth_blk);
         // A software write to the flag beats a same-cycle wrap.
         assign of_nxt = of_wr ? ((XLEN == 64) ? wv64[63] : wv64[31])
                               : (of_r | wrap_vec[gi]);
         always_ff @(posedge clk) begin
            if (reset) of_r <= 1'b0;
            else       of_r <= of_nxt;
         end
         assign of_reg[gi]  = of_r;
         assign of_next[gi] = of_nxt;
`else
         assign of_reg[gi]  = 1'b0;
         assign of_next[gi] = 1'b0;
`endif
      end else begin : g_no_evt
         assign sel_reg[gi] = '0;
         assign of_reg[gi]  = 1'b0;
         assign of_next[gi] = 1'b0;
      end
   end

`ifdef SSCOFPMF_EN
   // Registered from the next-state flags so the interrupt is visible in
   // the cycle right after the wrapping edge.
   logic lcof_reg;
   always_ff @(posedge clk) begin
      if (reset) lcof_reg <= 1'b0;
      else       lcof_reg <= |of_next;
   end
   assign LCOFIRQM = lcof_reg;
`else
   assign LCOFIRQM = 1'b0;
`endif

   always_comb begin
      rd64                     = '0;
      csr.IllegalCSRHPMAccessM = 1'b0;
      if (is_cnt_blk) begin
         rd64 = (XLEN == 64) ? cnt[idx] : {32'b0, cnt[idx][31:0]};
      end else if (is_cnth_blk) begin
         if (XLEN == 64) csr.IllegalCSRHPMAccessM = 1'b1;
         else            rd64 = {32'b0, cnt[idx][63:32]};
      end else if (is_evt_blk) begin
         rd64 = (XLEN == 64) ? {of_reg[idx], 55'b0, sel_reg[idx]} : {56'b0, sel_reg[idx]};
      end else if (is_evth_blk) begin
         if (XLEN == 64) csr.IllegalCSRHPMAccessM = 1'b1;
         else            rd64 = {32'b0, of_reg[idx], 31'b0};
      end
   end

   assign csr.CSRHPMReadValM = rd64[XLEN-1:0];

   assign unused_bits = ^{MCOUNTINHIBIT_REGW, wv64, wrap_vec, of_next, rd64};

endmodule

// File: tb/tb_csr_hpm_counters.sv
`timescale 1ns/1ps
module tb_csr_hpm_counters;

   logic        clk = 1'b0;
   logic        reset;
   logic        InstrRetiredM;
   logic [15:0] EventM;
   logic [31:0] inh;
   logic        lcof64, lcof32;

   always #5 clk = ~clk;

   csr_hpm_counters_if #(.XLEN(64)) bus64 ();
   csr_hpm_counters_if #(.XLEN(32)) bus32 ();

   csr_hpm_counters #(.XLEN(64), .NUM_HPM(4), .NUM_EVENTS(16)) dut64 (
      .clk(clk), .reset(reset), .csr(bus64), .InstrRetiredM(InstrRetiredM),
      .EventM(EventM), .MCOUNTINHIBIT_REGW(inh), .LCOFIRQM(lcof64));

   csr_hpm_counters #(.XLEN(32), .NUM_HPM(4), .NUM_EVENTS(16)) dut32 (
      .clk(clk), .reset(reset), .csr(bus32), .InstrRetiredM(InstrRetiredM),
      .EventM(EventM), .MCOUNTINHIBIT_REGW(inh), .LCOFIRQM(lcof32));

`ifdef SSCOFPMF_EN
   localparam bit OF_EN = 1'b1;
`else
   localparam bit OF_EN = 1'b0;
`endif

   typedef struct {
      bit          is32;
      logic [11:0] adr;
      logic [63:0] exp_data;
      bit          exp_ill;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input bit is32, input logic [11:0] adr, input logic [63:0] val);
      if (is32) begin
         bus32.CSRWriteM = 1'b1; bus32.CSRAdrM = adr; bus32.CSRWriteValM = val[31:0];
      end else begin
         bus64.CSRWriteM = 1'b1; bus64.CSRAdrM = adr; bus64.CSRWriteValM = val;
      end
      tick();
      bus32.CSRWriteM = 1'b0;
      bus64.CSRWriteM = 1'b0;
      $display("wr   %s adr=0x%0h val=0x%0h", is32 ? "rv32" : "rv64", adr, val);
   endtask

   // Read is combinational; sample 1ns after setting the address, then
   // realign to the next falling edge.
   task automatic rd(input bit is32, input logic [11:0] adr, output logic [63:0] data, output logic ill);
      if (is32) bus32.CSRAdrM = adr;
      else      bus64.CSRAdrM = adr;
      #1;
      data = is32 ? {32'b0, bus32.CSRHPMReadValM} : bus64.CSRHPMReadValM;
      ill  = is32 ? bus32.IllegalCSRHPMAccessM : bus64.IllegalCSRHPMAccessM;
      @(negedge clk);
   endtask

   task automatic rchk(input string name, input bit is32, input logic [11:0] adr, input logic [63:0] exp);
      logic [63:0] d;
      logic        il;
      rd(is32, adr, d, il);
      check(name, d, exp);
   endtask

   task automatic lchk(input string name, input bit is32, input bit exp);
      #1;
      check(name, {63'b0, is32 ? lcof32 : lcof64}, {63'b0, exp});
      @(negedge clk);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 12'hB00, 64'd101,  1'b0};
      vecs[1]  = '{1'b0, 12'hB01, 64'd0,    1'b0};
      vecs[2]  = '{1'b0, 12'hB02, 64'd3,    1'b0};
      vecs[3]  = '{1'b0, 12'hB03, 64'd5,    1'b0};
      vecs[4]  = '{1'b0, 12'hB04, 64'd0,    1'b0};
      vecs[5]  = '{1'b0, 12'hB05, 64'd0,    1'b0};
      vecs[6]  = '{1'b0, 12'hB06, 64'd3,    1'b0};
      vecs[7]  = '{1'b0, 12'hB07, 64'd0,    1'b0};
      vecs[8]  = '{1'b0, 12'hB10, 64'd0,    1'b0};
      vecs[9]  = '{1'b0, 12'hB80, 64'd0,    1'b1};
      vecs[10] = '{1'b0, 12'hB83, 64'd0,    1'b1};
      vecs[11] = '{1'b0, 12'h723, 64'd0,    1'b1};
      vecs[12] = '{1'b0, 12'h323, 64'h34,   1'b0};
      vecs[13] = '{1'b0, 12'h324, 64'h11,   1'b0};
      vecs[14] = '{1'b0, 12'h326, 64'h10,   1'b0};
      vecs[15] = '{1'b0, 12'h327, 64'd0,    1'b0};
      vecs[16] = '{1'b0, 12'h300, 64'd0,    1'b0};
      vecs[17] = '{1'b1, 12'hB00, 64'd12,   1'b0};
      vecs[18] = '{1'b1, 12'hB80, 64'd0,    1'b0};
      vecs[19] = '{1'b1, 12'hB02, 64'd3,    1'b0};
      vecs[20] = '{1'b1, 12'hB03, 64'h1234, 1'b0};
      vecs[21] = '{1'b1, 12'hB83, 64'hABCD, 1'b0};
      vecs[22] = '{1'b1, 12'h323, 64'd0,    1'b0};
      vecs[23] = '{1'b1, 12'h723, 64'd0,    1'b0};
      vecs[24] = '{1'b0, 12'hC00, 64'd0,    1'b0};

      reset = 1'b1; InstrRetiredM = 1'b0; EventM = '0; inh = '0;
      bus64.CSRWriteM = 1'b0; bus64.CSRAdrM = '0; bus64.CSRWriteValM = '0;
      bus32.CSRWriteM = 1'b0; bus32.CSRAdrM = '0; bus32.CSRWriteValM = '0;
      repeat (3) tick();

      // Reset state, then 10 free-running cycles
      rchk("reset_mcycle", 1'b0, 12'hB00, 64'd0);
      lchk("reset_lcof64", 1'b0, 1'b0);
      reset = 1'b0;
      repeat (10) tick();
      inh = '1;
      rchk("idle_mcycle64", 1'b0, 12'hB00, 64'd10);
      rchk("idle_minstret", 1'b0, 12'hB02, 64'd0);
      for (int n = 3; n <= 6; n++)
         rchk($sformatf("idle_hpm%0d", n), 1'b0, 12'(12'hB00 + n), 64'd0);
      rchk("idle_mcycle32", 1'b1, 12'hB00, 64'd10);

      // Event selection: only event 2 counts for mhpmcounter3
      wr(1'b0, 12'h323, 64'd2);
      inh = ~32'h8;
      EventM = 16'h0002; repeat (5) tick();
      EventM = 16'h0001; repeat (3) tick();
      EventM = '0; inh = '1;
      rchk("evt_hpm3", 1'b0, 12'hB03, 64'd5);

      // Selector boundaries: 17 (>NUM_EVENTS), 0, 16 (=NUM_EVENTS), 0x34
      wr(1'b0, 12'h324, 64'd17);
      wr(1'b0, 12'h325, 64'd0);
      wr(1'b0, 12'h326, 64'd16);
      wr(1'b0, 12'h323, 64'h1234);
      inh = ~32'h78;
      EventM = 16'hFFFF; repeat (3) tick();
      EventM = '0; inh = '1;

      // Write wins over increment, then counting resumes from written value
      inh = ~32'h1;
      wr(1'b0, 12'hB00, 64'd100);
      rchk("wr_mcycle_100", 1'b0, 12'hB00, 64'd100);
      inh = '1;
      rchk("wr_mcycle_101", 1'b0, 12'hB00, 64'd101);

      // minstret counts retirements, then holds while inhibited
      inh = ~32'h4; InstrRetiredM = 1'b1; repeat (3) tick();
      inh = '1; repeat (2) tick();
      InstrRetiredM = 1'b0;

      // RV64 wrap of mhpmcounter5
      wr(1'b0, 12'hB05, 64'hFFFF_FFFF_FFFF_FFFF);
      wr(1'b0, 12'h325, 64'd1);
      inh = ~32'h20; EventM = 16'h0001; tick();
      EventM = '0; inh = '1;
      rchk("wrap64_cnt", 1'b0, 12'hB05, 64'd0);
      rchk("wrap64_evt", 1'b0, 12'h325, OF_EN ? 64'h8000_0000_0000_0001 : 64'h1);
      lchk("wrap64_lcof", 1'b0, OF_EN);
      wr(1'b0, 12'h325, 64'd1);
      lchk("clr64_lcof", 1'b0, 1'b0);

      // RV32 wrap of mhpmcounter4 through both halves
      wr(1'b1, 12'hB04, 64'hFFFF_FFFF);
      wr(1'b1, 12'hB84, 64'hFFFF_FFFF);
      wr(1'b1, 12'h324, 64'd1);
      rchk("rv32_lo_ones", 1'b1, 12'hB04, 64'hFFFF_FFFF);
      inh = ~32'h10; EventM = 16'h0001; tick();
      EventM = '0; inh = '1;
      rchk("wrap32_lo", 1'b1, 12'hB04, 64'd0);
      rchk("wrap32_hi", 1'b1, 12'hB84, 64'd0);
      rchk("wrap32_evth", 1'b1, 12'h724, OF_EN ? 64'h8000_0000 : 64'h0);
      lchk("wrap32_lcof", 1'b1, OF_EN);
      wr(1'b1, 12'h724, 64'd0);
      lchk("clr32_lcof", 1'b1, 1'b0);
      rchk("clr32_evth", 1'b1, 12'h724, 64'd0);
      rchk("clr32_evt", 1'b1, 12'h324, 64'd1);

      // RV32 half writes hold the other half
      wr(1'b1, 12'hB83, 64'hABCD);
      rchk("half_lo_held", 1'b1, 12'hB03, 64'd0);
      wr(1'b1, 12'hB03, 64'h1234);
      rchk("half_hi_held", 1'b1, 12'hB83, 64'hABCD);

      // Writes to unimplemented locations are ignored
      wr(1'b0, 12'hB07, 64'd99);
      wr(1'b0, 12'h327, 64'd5);
      wr(1'b0, 12'hB01, 64'd7);

      for (int i = 0; i < NV; i++) begin
         logic [63:0] d;
         logic        il;
         rd(vecs[i].is32, vecs[i].adr, d, il);
         check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
         check($sformatf("vec%0d_ill", i), {63'b0, il}, {63'b0, vecs[i].exp_ill});
      end

      // Reset mid-count with a concurrent minstret write
      inh = '0; InstrRetiredM = 1'b1; EventM = '1;
      repeat (2) tick();
      reset = 1'b1;
      bus64.CSRWriteM = 1'b1; bus64.CSRAdrM = 12'hB02; bus64.CSRWriteValM = 64'd55;
      bus32.CSRWriteM = 1'b1; bus32.CSRAdrM = 12'hB02; bus32.CSRWriteValM = 32'd55;
      tick();
      bus64.CSRWriteM = 1'b0; bus32.CSRWriteM = 1'b0;
      inh = '1; InstrRetiredM = 1'b0; EventM = '0; reset = 1'b0;
      rchk("rst_mcycle", 1'b0, 12'hB00, 64'd0);
      rchk("rst_minstret64", 1'b0, 12'hB02, 64'd0);
      rchk("rst_hpm3", 1'b0, 12'hB03, 64'd0);
      rchk("rst_hpm6", 1'b0, 12'hB06, 64'd0);
      rchk("rst_evt3", 1'b0, 12'h323, 64'd0);
      rchk("rst_minstret32", 1'b1, 12'hB02, 64'd0);
      rchk("rst_hpm3h32", 1'b1, 12'hB83, 64'd0);
      lchk("rst_lcof64", 1'b0, 1'b0);
      lchk("rst_lcof32", 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
